seg_digit_counter: RTL and testbench
====================================

# seg_digit_counter

Prescaled single-digit counter that drives the 4-bit input `{d,c,b,a}` of the seven-segment hex decoder directly downstream. The counter steps once per prescaler tick and counts up or down modulo `MODULUS`, with wrap-around. A raw push-button toggles the counter between run and pause. A synchronous load and a terminal-count pulse allow a digit to be preset and allow several digits to be chained.

## Interface
- `CLK_DIV`, default 50_000_000: clock cycles per count step. Legal range is ≥ 2.
- `MODULUS`, default 10: count range 0..MODULUS-1. Legal range is 2..16. Use 16 for hex display.
- `clk`  in  1  system clock. All logic is on the rising edge.
- `rst_n`  in  1  reset. Asynchronous and active-low. Assertion is asynchronous; deassertion is synchronized externally.
- `en`  in  1  synchronous count enable. When low, the prescaler and the digit both freeze.
- `up`  in  1  direction. 1 counts up, 0 counts down. Sampled on the tick cycle.
- `btn_run`  in  1  raw, asynchronous, active-high button. Each rising edge toggles RUN/PAUSE.
- `load`  in  1  synchronous load strobe.
- `load_val`  in  4  value to load.
- `a`,`b`,`c`,`d`  out  1 each  registered digit. `a` is the LSB and `d` is the MSB, matching the decoder pin order.
- `tc`  out  1  one-cycle terminal-count (carry/borrow) pulse.
- `tick`  out  1  one-cycle prescaler strobe. Used for chaining and debug.
- `running`  out  1  high while in RUN.

## Operation
- FSM, two states: PAUSE (reset state) and RUN.
  - A synchronized rising edge on `btn_run` toggles the state.
  - A level held high on `btn_run` causes exactly one toggle.
  - There is no debounce inside this block. Bounce produces multiple toggles, and filtering is the board-level responsibility.
- Prescaler: a ceil(log2(CLK_DIV))-bit counter.
  - Advances only when state = RUN and `en` = 1.
  - On reaching CLK_DIV-1 it returns to 0 and `tick` = 1 for that cycle. `tick` is combinational from the prescaler compare, qualified by RUN and `en`.
  - In PAUSE, or with `en` = 0, the prescaler holds its value and does not clear.
- Digit update priority, highest first:
  1. `load`: digit ← min(load_val, MODULUS-1). The prescaler clears to 0 in the same cycle. `tc` = 0.
  2. `tick` with `up` = 1: if digit = MODULUS-1, then digit ← 0 and `tc` = 1. Otherwise digit + 1.
  3. `tick` with `up` = 0: if digit = 0, then digit ← MODULUS-1 and `tc` = 1. Otherwise digit − 1.
  4. Otherwise the digit holds and `tc` = 0.
- `load` is honoured in either state and regardless of `en`.
- Arithmetic is 4-bit unsigned. No intermediate value may exceed 4 bits. Wrap is by explicit compare, never by natural overflow, except at MODULUS = 16 where the two coincide.
- Reset values (asynchronous, effective immediately):
  - digit = 0, so `{d,c,b,a}` = 0000 and the decoder shows "0".
  - `tc` = 0, `tick` = 0, `running` = 0, state = PAUSE.
  - Prescaler = 0, synchronizer and edge flops = 0.
- Reset mid-count abandons the prescaler phase. After release, counting restarts from a full CLK_DIV period once RUN is re-entered.

## Timing
- `btn_run` path is two-flop synchronizer, then an edge register.
  - `running` changes on the 3rd rising `clk` edge after `btn_run` rises, given `btn_run` meets setup before the 1st.
  - A pulse shorter than one clock may be missed, and that is accepted.
- In RUN with `en` = 1, the first `tick` occurs CLK_DIV cycles after entering RUN from a cleared prescaler.
- `tick` then repeats every CLK_DIV enabled cycles.
- Digit and `tc` are registered and update on the edge that ends the `tick` cycle: one cycle of latency from `tick` to the new digit. `tc` is high for exactly that one cycle.
- `load` takes effect on the next edge. The new digit is visible one cycle after `load` is sampled.
- Load and tick in the same cycle: the load wins and the tick is discarded.
- Button toggle and tick in the same cycle: the tick still updates the digit, and the state changes on that same edge.

## Structure
- Shared package `seg_pkg`:
  - State enum `run_state_t` = {PAUSE, RUN}.
  - Constant `SEG_DIGIT_W` = 4.
  - Function `clog2` for prescaler sizing.
- Sub-module `seg_sync_edge`: two-flop synchronizer plus a rising-edge pulse. It has reset and one output, and is reused for future button inputs.
- Digit and `tc` live in one always block. The prescaler lives in its own block.

## Test plan
Simulation uses CLK_DIV = 4 unless stated otherwise.
1. Reset, then `btn_run` pulse, MODULUS = 10, up = 1, en = 1 → `running` rises 3 edges after the pulse; the digit steps 0→1→…→9→0 every 4 cycles; `tc` is a single pulse at the 9→0 step.
2. Down count: load 0 with up = 0 in RUN → next tick gives digit = 9 with `tc` = 1, then 8 with `tc` = 0.
3. Load clamp, MODULUS = 10: load_val = 4'hC → digit = 9. With MODULUS = 16, load_val = 4'hF → F, then the next up tick gives 0 with `tc` = 1.
4. Collisions: assert `load` (load_val = 3) on the tick cycle → digit = 3, no `tc`, prescaler restarts at 0. Hold `en` = 0 for 10 cycles → digit and prescaler frozen; when `en` returns, the next tick arrives after the remaining phase.
5. Pause and button level: hold `btn_run` high for 20 cycles from PAUSE → exactly one toggle to RUN. A second rising edge → PAUSE, with digit and prescaler held; resuming continues from the held phase.
6. Asynchronous reset at prescaler = 2 with digit = 7 → all outputs 0 immediately, before any clock edge; after release, state = PAUSE and digit = 0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and sizing helpers for the seven-segment digit counter family.
package seg_pkg;

  typedef enum logic {
    PAUSE = 1'b0,
    RUN   = 1'b1
  } run_state_t;

  localparam int SEG_DIGIT_W = 4;

  // Smallest width w such that 2**w >= value; used to size the prescaler.
  function automatic int clog2(input int value);
    int w;
    int p;
    w = 32'sd0;
    p = 32'sd1;
    while (p < value) begin
      p = p * 32'sd2;
      w = w + 32'sd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/seg_sync_edge.sv
// Two-flop synchronizer for an asynchronous input followed by a rising-edge
// detector; pulse is high for one cycle per synchronized rising edge.
module seg_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic sync1_r;
  logic sync2_r;
  logic edge_r;

  // Synchronizer chain plus delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      edge_r  <= 1'b0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
      edge_r  <= sync2_r;
    end
  end

  assign pulse = sync2_r & ~edge_r;

endmodule

// File: rtl/seg_digit_counter.sv
// Prescaled up/down single-digit counter with run/pause button, synchronous
// load and terminal-count pulse, driving a hex decoder's {d,c,b,a} inputs.
module seg_digit_counter
  import seg_pkg::*;
#(
  parameter int CLK_DIV = 50_000_000,
  parameter int MODULUS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       btn_run,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       tc,
  output logic       tick,
  output logic       running
);

  localparam int PRESC_W = clog2(CLK_DIV);
  localparam logic [PRESC_W-1:0]     PRESC_LAST = PRESC_W'(CLK_DIV - 1);
  localparam logic [SEG_DIGIT_W-1:0] DIGIT_MAX  = SEG_DIGIT_W'(MODULUS - 1);

  run_state_t             state_r;
  run_state_t             state_nxt_s;
  logic                   btn_rise_s;
  logic                   advance_s;
  logic                   tick_s;
  logic [PRESC_W-1:0]     presc_r;
  logic [SEG_DIGIT_W-1:0] digit_r;
  logic [SEG_DIGIT_W-1:0] load_clamp_s;
  logic                   tc_r;

  seg_sync_edge u_btn_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (btn_run),
    .pulse (btn_rise_s)
  );

  // Run/pause state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= PAUSE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Each synchronized button edge flips between PAUSE and RUN.
  always_comb begin
    state_nxt_s = state_r;
    if (btn_rise_s) begin
      case (state_r)
        PAUSE:   state_nxt_s = RUN;
        RUN:     state_nxt_s = PAUSE;
        default: state_nxt_s = PAUSE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Prescaler advance/tick qualification and load-value clamp.
  always_comb begin
    advance_s = (state_r == RUN) && en;
    tick_s    = advance_s && (presc_r == PRESC_LAST);
    if (load_val > DIGIT_MAX) begin
      load_clamp_s = DIGIT_MAX;
    end else begin
      load_clamp_s = load_val;
    end
  end

  // Prescaler: cleared by load, otherwise wraps at CLK_DIV-1 while advancing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= '0;
    end else if (load) begin
      presc_r <= '0;
    end else if (advance_s) begin
      if (presc_r == PRESC_LAST) begin
        presc_r <= '0;
      end else begin
        presc_r <= presc_r + PRESC_W'(1);
      end
    end else begin
      presc_r <= presc_r;
    end
  end

  // Digit and terminal count; wrap is by explicit compare against the modulus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_r <= 4'd0;
      tc_r    <= 1'b0;
    end else if (load) begin
      digit_r <= load_clamp_s;
      tc_r    <= 1'b0;
    end else if (tick_s && up) begin
      if (digit_r == DIGIT_MAX) begin
        digit_r <= 4'd0;
        tc_r    <= 1'b1;
      end else begin
        digit_r <= digit_r + 4'd1;
        tc_r    <= 1'b0;
      end
    end else if (tick_s) begin
      if (digit_r == 4'd0) begin
        digit_r <= DIGIT_MAX;
        tc_r    <= 1'b1;
      end else begin
        digit_r <= digit_r - 4'd1;
        tc_r    <= 1'b0;
      end
    end else begin
      digit_r <= digit_r;
      tc_r    <= 1'b0;
    end
  end

  assign {d, c, b, a} = digit_r;
  assign tc           = tc_r;
  assign tick         = tick_s;
  assign running      = (state_r == RUN);

endmodule

// File: tb/tb_seg_digit_counter.sv
// Scoreboard bench: a behavioural model pushes expected outputs per clock edge,
// a monitor pops and compares them on the falling edge. Two DUTs (mod 10, mod 16).
module tb_seg_digit_counter;

  localparam int DIV  = 4;
  localparam int MOD0 = 10;
  localparam int MOD1 = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       up;
  logic       btn_run;
  logic       load;
  logic [3:0] load_val;

  logic a0, b0, c0, d0, tc0, tick0, run0;
  logic a1, b1, c1, d1, tc1, tick1, run1;

  always #5 clk = ~clk;

  seg_digit_counter #(.CLK_DIV(DIV), .MODULUS(MOD0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .btn_run(btn_run),
    .load(load), .load_val(load_val),
    .a(a0), .b(b0), .c(c0), .d(d0), .tc(tc0), .tick(tick0), .running(run0)
  );

  seg_digit_counter #(.CLK_DIV(DIV), .MODULUS(MOD1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .btn_run(btn_run),
    .load(load), .load_val(load_val),
    .a(a1), .b(b1), .c(c1), .d(d1), .tc(tc1), .tick(tick1), .running(run1)
  );

  typedef struct {
    int dig0;
    int dig1;
    bit tc0;
    bit tc1;
    bit run;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: phase counts enabled RUN cycles modulo DIV.
  int       m_phase;
  int       m_dig[2];
  bit       m_tc[2];
  bit       m_run;
  bit [3:0] m_hist;
  int       mods[2] = '{MOD0, MOD1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.dig0 = m_dig[0];
    e.dig1 = m_dig[1];
    e.tc0  = m_tc[0];
    e.tc1  = m_tc[1];
    e.run  = m_run;
    return e;
  endfunction

  // Behavioural model, stepped on every clock edge (or reset assertion).
  always @(posedge clk or negedge rst_n) begin : model
    bit tk;
    bit tog;
    int lv;
    if (!rst_n) begin
      m_phase = 0;
      m_dig   = '{0, 0};
      m_tc    = '{1'b0, 1'b0};
      m_run   = 1'b0;
      m_hist  = 4'b0000;
      sb_q.delete();
      sb_q.push_back(snap());
    end else begin
      tk     = m_run && en && (m_phase == DIV - 1);
      m_hist = {m_hist[2:0], btn_run};
      tog    = m_hist[2] && !m_hist[3];
      lv     = load_val;
      for (int i = 0; i < 2; i++) begin
        if (load) begin
          m_dig[i] = (lv > mods[i] - 1) ? mods[i] - 1 : lv;
          m_tc[i]  = 1'b0;
        end else if (tk) begin
          if (up) begin
            m_tc[i]  = (m_dig[i] == mods[i] - 1);
            m_dig[i] = (m_dig[i] + 1) % mods[i];
          end else begin
            m_tc[i]  = (m_dig[i] == 0);
            m_dig[i] = (m_dig[i] + mods[i] - 1) % mods[i];
          end
        end else begin
          m_tc[i] = 1'b0;
        end
      end
      if (load) m_phase = 0;
      else if (m_run && en) m_phase = (m_phase + 1) % DIV;
      if (tog) m_run = !m_run;
      sb_q.push_back(snap());
    end
  end

  // Monitor: the DUT presents a fresh output set every cycle.
  always @(negedge clk) begin
    exp_t e;
    bit   etick;
    if (sb_q.size() > 0) begin
      e     = sb_q.pop_front();
      etick = m_run && en && (m_phase == DIV - 1);
      check("digit_m10", {28'd0, d0, c0, b0, a0}, e.dig0);
      check("digit_m16", {28'd0, d1, c1, b1, a1}, e.dig1);
      check("tc_m10", {31'd0, tc0}, {31'd0, e.tc0});
      check("tc_m16", {31'd0, tc1}, {31'd0, e.tc1});
      check("running", {31'd0, run0}, {31'd0, e.run});
      check("running_m16", {31'd0, run1}, {31'd0, e.run});
      check("tick", {31'd0, tick0}, {31'd0, etick});
      check("tick_m16", {31'd0, tick1}, {31'd0, etick});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic btn_pulse(input int len);
    btn_run = 1'b1;
    step(len);
    btn_run = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; up = 1'b1; btn_run = 1'b0; load = 1'b0; load_val = 4'd0;
    step(3);
    rst_n = 1'b1;
    check("reset_digit", {28'd0, d0, c0, b0, a0}, 32'd0);
    check("reset_running", {31'd0, run0}, 32'd0);

    // Start running, count up through a full wrap.
    en = 1'b1; up = 1'b1;
    btn_pulse(1);
    step(48);

    // Down count from 0 wraps to MODULUS-1.
    up = 1'b0; load = 1'b1; load_val = 4'd0;
    step(1);
    load = 1'b0;
    step(10);

    // Load clamp, then the wrap at the loaded maximum.
    up = 1'b1; load = 1'b1; load_val = 4'hC;
    step(1);
    check("clamp_m10", {28'd0, d0, c0, b0, a0}, 32'd9);
    load_val = 4'hF;
    step(1);
    load = 1'b0;
    check("load_f_m16", {28'd0, d1, c1, b1, a1}, 32'd15);
    step(6);

    // Load colliding with tick, then enable held low.
    for (int k = 0; k < 2 * DIV + 2 && !(m_run && en && m_phase == DIV - 1); k++) step(1);
    check("tick_wait", {31'd0, tick0}, 32'd1);
    load = 1'b1; load_val = 4'd3;
    step(1);
    load = 1'b0;
    step(2);
    en = 1'b0;
    step(10);
    en = 1'b1;
    step(8);

    // Button: pause, long hold (one toggle), pause again, resume.
    btn_pulse(1);
    step(5);
    btn_pulse(20);
    step(6);
    btn_pulse(2);
    step(10);
    btn_pulse(1);
    step(12);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      en       = ($urandom_range(0, 9) != 0);
      up       = $urandom_range(0, 1);
      load     = ($urandom_range(0, 29) == 0);
      load_val = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) btn_run = ~btn_run;
      step(1);
    end
    btn_run = 1'b0; load = 1'b0; en = 1'b1;
    step(4);

    // Asynchronous reset with prescaler = 2 and digit = 7.
    if (!m_run) begin
      btn_pulse(1);
      step(4);
    end
    load = 1'b1; load_val = 4'd7;
    step(1);
    load = 1'b0;
    for (int k = 0; k < 10 && !(m_phase == 2 && m_dig[0] == 7); k++) step(1);
    check("pre_reset_phase", m_phase, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_digit", {28'd0, d0, c0, b0, a0}, 32'd0);
    check("async_tc", {31'd0, tc0}, 32'd0);
    check("async_tick", {31'd0, tick0}, 32'd0);
    check("async_running", {31'd0, run0}, 32'd0);
    step(3);
    rst_n = 1'b1;
    step(6);
    check("post_reset_running", {31'd0, run0}, 32'd0);
    check("post_reset_digit", {28'd0, d0, c0, b0, a0}, 32'd0);
    check("scoreboard_activity", {31'd0, (n_tests > 1000)}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
